fifo_burst_reader: RTL
======================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter: width, default 16, data word width in bits.
REQ-002 Parameter: len_w, default 4, width of burst length and word counter.
REQ-003 Port: clk  input  1  single clock; all logic is rising-edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle burst request, sampled only in IDLE.
REQ-006 Port: burst_len  input  len_w  number of words to read, sampled with start.
REQ-007 Port: fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 Port: fifo_data  input  width  upstream FIFO read data, valid one cycle after an accepted read.
REQ-009 Port: fifo_re  output  1  read enable to upstream FIFO.
REQ-010 Port: m_data  output  width  downstream data.
REQ-011 Port: m_valid  output  1  downstream data valid.
REQ-012 Port: m_ready  input  1  downstream ready.
REQ-013 Port: busy  output  1  high from accepted start until done.
REQ-014 Port: done  output  1  one-cycle pulse at burst completion.
REQ-015 Port: words_out  output  len_w  words delivered downstream in current/last burst.

Function
REQ-016 States: IDLE, READ, DRAIN, DONE; one-hot or binary encoding is an implementation choice.
REQ-017 IDLE: start=1 and burst_len!=0 -> READ; latch burst_len into remaining-read counter, clear words_out, assert busy next cycle.
REQ-018 IDLE: start=1 and burst_len=0 -> DONE directly; no FIFO read issued.
REQ-019 Read accepted when fifo_re=1 and fifo_empty=0 in the same cycle; fifo_re is combinationally gated with !fifo_empty, so fifo_re is never high while fifo_empty=1.
REQ-020 fifo_re is asserted in READ only when remaining>0 and (buffered words + in-flight reads) < 2.
REQ-021 Read data is captured from fifo_data exactly one cycle after an accepted read into a 2-entry output buffer (skid); no data word is dropped or duplicated.
REQ-022 m_valid=1 whenever the buffer is non-empty; m_data is the oldest buffered word; a word retires when m_valid=1 and m_ready=1.
REQ-023 m_data/m_valid stay stable while m_valid=1 and m_ready=0.
REQ-024 Simultaneous capture and retire in one cycle keeps buffer occupancy unchanged and preserves order.
REQ-025 Sustained throughput: with fifo_empty=0 and m_ready=1 continuously, one word per cycle after a 2-cycle initial latency (start -> first m_valid).
REQ-026 READ -> DRAIN when the last read is accepted (remaining reaches 0).
REQ-027 DRAIN -> DONE when the buffer is empty and no read is in flight.
REQ-028 DONE lasts one cycle: done=1, busy=0, then -> IDLE.
REQ-029 words_out increments by 1 on each retire; saturates at 2^len_w-1; held after done until next accepted start.
REQ-030 start while not IDLE is ignored; burst_len changes after acceptance have no effect.
REQ-031 fifo_empty=1 during READ stalls reads indefinitely without timeout; buffered words continue to drain.
REQ-032 m_ready=0 during READ stops new reads once occupancy+in-flight reaches 2.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, fifo_re=0, m_valid=0, m_data=0, busy=0, done=0, words_out=0, buffer and counters cleared.
REQ-034 Reset mid-burst discards buffered and in-flight data; a fifo_data word arriving the cycle after reset is ignored.

Verification
REQ-035 FIFO preloaded 1..8, burst_len=8, m_ready=1 -> m_data 1..8 on 8 consecutive cycles, first m_valid 2 cycles after start, done 1 cycle after last retire, words_out=8.
REQ-036 FIFO preloaded 1..4, burst_len=4, m_ready toggled 1,0,0,1,... -> m_data sequence 1,2,3,4 exactly once each, held while m_ready=0, fifo_re never raises occupancy above 2.
REQ-037 FIFO empty, burst_len=3, then words 5,6,7 written 10 cycles apart -> m_data 5,6,7 in order, busy high throughout, done after third retire.
REQ-038 start with burst_len=0 -> done pulse next cycle, fifo_re never asserted, words_out=0.
REQ-039 rst asserted after 2 of 6 words delivered -> all outputs to reset values next cycle, no further m_valid, subsequent burst_len=2 start reads the next 2 FIFO words correctly.
REQ-040 start pulsed during active burst of 4 -> ignored; exactly 4 words delivered and one done pulse.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Reads a burst of burst_len words from an upstream FIFO into a 2-entry skid buffer and streams them out.
// Latency: first m_valid on the second clock edge after start is sampled; then one word per cycle.
// Backpressure: m_ready low holds m_data/m_valid and stops new reads once buffer plus in-flight reaches 2.
module fifo_burst_reader #(
  parameter int width = 16,
  parameter int len_w = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [len_w-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic [width-1:0]  fifo_data,
  output logic              fifo_re,
  output logic [width-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [len_w-1:0]  words_out
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [len_w-1:0]   remaining_q, remaining_d;
  logic [len_w-1:0]   words_out_q, words_out_d;
  logic [1:0]         count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [width-1:0]   buf0_q, buf0_d;
  logic [width-1:0]   buf1_q, buf1_d;

  logic               retire;
  logic [2:0]         occ_next;
  logic [1:0]         wr_slot;

  always_comb begin
    retire   = (count_q != 2'd0) && m_ready;
    // Occupancy as seen after this cycle's retire, so a read can issue every cycle at full rate.
    occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, retire};
    fifo_re  = (state_q == S_READ) && (remaining_q != '0) && (occ_next < 3'd2) && !fifo_empty;

    state_d     = state_q;
    remaining_d = fifo_re ? remaining_q - len_w'(1) : remaining_q;
    inflight_d  = fifo_re;
    count_d     = count_q + {1'b0, inflight_q} - {1'b0, retire};
    words_out_d = words_out_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    wr_slot     = count_q - {1'b0, retire};

    if (retire) begin
      buf0_d = buf1_q;
      if (words_out_q != '1) words_out_d = words_out_q + len_w'(1);
    end
    if (inflight_q) begin
      if (wr_slot == 2'd0) buf0_d = fifo_data;
      else                 buf1_d = fifo_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          words_out_d = '0;
          if (burst_len == '0) begin
            state_d = S_DONE;
          end else begin
            remaining_d = burst_len;
            state_d     = S_READ;
          end
        end
      end
      S_READ: begin
        if (fifo_re && (remaining_q == len_w'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((count_d == 2'd0) && !inflight_d) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      words_out_q <= '0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      words_out_q <= words_out_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = buf0_q;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign words_out = words_out_q;

endmodule
